// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared widths, opcode indices and state encoding for the ALU sequencer
package alu_sequencer_pkg;
  localparam int W = 32;
  localparam int CTRL_W = 12;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR = 4'd9;
  localparam logic [3:0] OP_XOR = 4'd10;
  localparam logic [3:0] OP_NOR = 4'd11;
  localparam logic [3:0] OP_ILLEGAL = 4'd12;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, OUT_LO = 2'd2, OUT_HI = 2'd3} state_t;
endpackage

// File: rtl/op_decoder.sv
// op_decoder: 4-bit op index to one-hot ALU control word, zero for illegal ops
module op_decoder
  import alu_sequencer_pkg::*;
(
  input  logic [3:0]        op,
  output logic [CTRL_W-1:0] ctrl
);
  assign ctrl = (op < OP_ILLEGAL) ? CTRL_W'(1) << op : '0;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one ALU operation over a shared 32-bit bus, returning LO then optional HI word
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [W-1:0]      bus_in,
  input  logic [2*W-1:0]    alu_result,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [W-1:0]      alu_x,
  output logic [W-1:0]      alu_y,
  output logic [W-1:0]      bus_out,
  output logic              bus_out_valid,
  output logic              out_is_hi,
  output logic              busy,
  output logic              done,
  output logic              error
);
  state_t state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic [2*W-1:0] z_q, z_d;
  logic [3:0] op_q, op_d;
  logic error_q, error_d;
  logic [CTRL_W-1:0] ctrl;
  logic wide;

  op_decoder u_dec (.op(op_q), .ctrl(ctrl));

  assign wide = op_q == OP_MUL || op_q == OP_DIV;
  assign busy = state_q != IDLE;
  assign error = error_q;
  assign alu_y = y_q;

  always_comb begin
    state_d = state_q;
    y_d = y_q;
    z_d = z_q;
    op_d = op_q;
    error_d = 1'b0;
    alu_ctrl = '0;
    alu_x = '0;
    bus_out = '0;
    bus_out_valid = 1'b0;
    out_is_hi = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        error_d = opcode >= OP_ILLEGAL;
        if (opcode < OP_ILLEGAL) begin
          y_d = bus_in;
          op_d = opcode;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_ctrl = ctrl;
        alu_x = bus_in;
        z_d = alu_result;
        state_d = OUT_LO;
      end
      OUT_LO: begin
        bus_out = z_q[W-1:0];
        bus_out_valid = 1'b1;
        done = !wide;
        state_d = wide ? OUT_HI : IDLE;
      end
      OUT_HI: begin
        bus_out = z_q[2*W-1:W];
        bus_out_valid = 1'b1;
        out_is_hi = 1'b1;
        done = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      y_q <= '0;
      z_q <= '0;
      op_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q <= y_d;
      z_q <= z_d;
      op_q <= op_d;
      error_q <= error_d;
    end
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 clear  in  1  asynchronous active-high reset.
REQ-004 start  in  1  request to begin one ALU operation; sampled only in IDLE.
REQ-005 opcode  in  4  operation index 0-11, matching the ALU control bit positions (0 add, 1 sub, 2 mul, 3 div, 8 AND, 9 OR, ...); 12-15 illegal.
REQ-006 bus_in  in  32  shared bus: carries the Y operand in the start cycle and the X operand in the EXEC cycle.
REQ-007 alu_result  in  64  combinational 64-bit result from the ALU.
REQ-008 alu_ctrl  out  12  one-hot ALU control word.
REQ-009 alu_x  out  32  ALU X operand.
REQ-010 alu_y  out  32  ALU Y operand, taken from the internal Y register.
REQ-011 bus_out  out  32  result word driven back to the bus.
REQ-012 bus_out_valid  out  1  bus_out holds a result word.
REQ-013 out_is_hi  out  1  bus_out carries Z[63:32].
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse on the final result word.
REQ-016 error  out  1  one-cycle pulse on an illegal-opcode start.

Function
REQ-017 States SHALL be IDLE, EXEC, OUT_LO and OUT_HI, with internal registers Y (32 bits), Z (64 bits) and op (4 bits).
REQ-018 IDLE, on start=1 with opcode<=11: Y<=bus_in, op<=opcode, next state EXEC.
REQ-019 IDLE, on start=1 with opcode>=12: error=1 in the following cycle, state stays IDLE, and Y and op are unchanged.
REQ-020 EXEC: alu_ctrl SHALL equal 1<<op, alu_x=bus_in and alu_y=Y; Z<=alu_result at the closing edge; next state OUT_LO.
REQ-021 OUT_LO: bus_out=Z[31:0], bus_out_valid=1, out_is_hi=0; next state OUT_HI if op is 2 or 3, otherwise IDLE with done=1 in this cycle.
REQ-022 OUT_HI: bus_out=Z[63:32], bus_out_valid=1, out_is_hi=1, done=1; next state IDLE.
REQ-023 Outside EXEC, alu_ctrl SHALL be 0 and alu_x SHALL be 0.
REQ-024 Outside the output states, bus_out SHALL be 0 and bus_out_valid SHALL be 0.
REQ-025 Latency: if start is accepted at edge N, the LO word is valid in cycle N+2 and, for mul/div, the HI word in cycle N+3.
REQ-026 start asserted while busy=1 SHALL be ignored, with no queuing and no error.
REQ-027 A start in the same cycle that done is high SHALL be ignored; the earliest accepted start is the cycle after return to IDLE.
REQ-028 Z SHALL be captured unmodified; any sign or width handling is the ALU's responsibility.

Reset
REQ-029 clear=1 SHALL immediately force state IDLE, Y=0, Z=0, op=0, and all outputs to 0, from any state including EXEC and OUT_LO/OUT_HI.
REQ-030 After clear is released, the first start SHALL be accepted at the next rising edge.

Structure
REQ-031 A shared package SHALL hold: the width constant 32; the control width 12; the opcode index constants (ADD=0, SUB=1, MUL=2, DIV=3, AND=8, OR=9, ...); the 2-bit state encoding; and the illegal-opcode threshold 12.
REQ-032 One sub-module, op_decoder, SHALL convert the 4-bit op into the 12-bit one-hot word, giving 0 for illegal values.
REQ-033 The bench SHALL connect alu_sequencer to the existing alu instance, wiring alu_x/alu_y/alu_ctrl to the ALU inputs and OpResult to alu_result.

Verification
REQ-034 Add: start with opcode=0 and bus_in=5, then bus_in=3 in EXEC -> cycle N+2: bus_out=8, bus_out_valid=1, done=1; busy=0 next cycle.
REQ-035 Mul: opcode=2, Y=-5, X=15 -> LO 0xFFFFFFB5 at N+2 with done=0; HI 0xFFFFFFFF at N+3 with out_is_hi=1 and done=1.
REQ-036 Div: opcode=3, Y=5, X=-15 -> LO 0xFFFFFFFD, HI 0x00000000 on consecutive cycles, with done on the HI word only.
REQ-037 Illegal opcode: start with opcode=13 -> error pulses for exactly one cycle, busy stays 0, alu_ctrl stays 0.
REQ-038 Busy/abort: start during EXEC is ignored (still one result); clear asserted during OUT_LO of a mul -> all outputs are 0 immediately, no HI word appears, and a new add after release returns the correct value.
